// File: rtl/buzzer_melody_player_pkg.sv
// Shared definitions for the buzzer melody player: FSM states and the
// layout of one melody ROM entry.
package buzzer_melody_player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam int HP_MSB  = 31;
    localparam int HP_LSB  = 16;
    localparam int DUR_MSB = 15;
    localparam int DUR_LSB = 0;

    // A zero duration marks the end of the melody.
    localparam logic [15:0] END_DUR = 16'd0;

    function automatic logic [15:0] entry_hp(input logic [31:0] entry);
        return entry[HP_MSB:HP_LSB];
    endfunction

    function automatic logic [15:0] entry_dur(input logic [31:0] entry);
        return entry[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/buzzer_melody_player_tone_gen.sv
// Square-wave generator: half-period counter with output toggle.
// Disabled means counter cleared and output forced low.
module buzzer_tone_gen (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [15:0] half_period,
    output logic        buzzer
);

    logic [15:0] cnt_q, cnt_d;
    logic        tog_q, tog_d;

    // Next counter / toggle value; a zero half-period is a rest and never toggles.
    always_comb begin
        cnt_d = '0;
        tog_d = 1'b0;
        if (en) begin
            if (cnt_q >= half_period) begin
                cnt_d = '0;
                tog_d = (half_period != 16'd0) ? ~tog_q : 1'b0;
            end else begin
                cnt_d = cnt_q + 16'd1;
                tog_d = tog_q;
            end
        end
    end

    // Counter and toggle registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tog_q <= tog_d;
        end
    end

    // Gate with en so the pin drops in the very first cycle after a note ends.
    assign buzzer = tog_q & en;

endmodule

// File: rtl/buzzer_melody_player.sv
// Melody sequencer: walks a synchronous note ROM, plays each note as a
// square wave for its duration, then a silent gap.
// Optional build macro MELODY_LOOP_EN: restart from address 0 after the
// melody end instead of going idle (an end marker at address 0 still idles).
//
// state | meaning
// IDLE  | waiting for start
// FETCH | ROM address presented, data arrives next cycle
// LOAD  | entry decoded: end marker or latch note
// PLAY  | tone output for dur ticks
// GAP   | silence for GAP_TICKS ticks
// NEXT  | advance address or finish at last address
// DONE  | one-cycle done pulse
module buzzer_melody_player
    import buzzer_melody_player_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              busy,
    output logic              done,
    output logic              buzzer
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [15:0]        GAP_LOAD   = 16'(GAP_TICKS);
    localparam bit                 HAS_GAP    = (GAP_TICKS > 0);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         hp_q, hp_d;
    logic [15:0]         rem_q, rem_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;

    // Next-state, address, note latch and tick/duration counting; stop overrides all.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hp_d    = hp_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                if (entry_dur(rom_data) == END_DUR) begin
                    state_d = ST_DONE;
                end else begin
                    hp_d    = entry_hp(rom_data);
                    rem_d   = entry_dur(rom_data);
                    presc_d = '0;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY, ST_GAP: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        if (state_q == ST_PLAY && HAS_GAP) begin
                            state_d = ST_GAP;
                            rem_d   = GAP_LOAD;
                        end else begin
                            state_d = ST_NEXT;
                        end
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_NEXT: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                addr_d = '0;
`ifdef MELODY_LOOP_EN
                // Done at address 0 means the melody is empty: do not spin.
                state_d = (addr_q != '0) ? ST_FETCH : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        if (stop) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            rem_d   = '0;
            presc_d = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            hp_q    <= '0;
            rem_q   <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hp_q    <= hp_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
        end
    end

    buzzer_tone_gen u_tone (
        .clk         (clk),
        .resetn      (resetn),
        .en          (state_q == ST_PLAY),
        .half_period (hp_q),
        .buzzer      (buzzer)
    );

    assign rom_addr = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_buzzer_melody_player.sv
// Bench for buzzer_melody_player (default build, no looping).
module tb_buzzer_melody_player;

    localparam int AW  = 3;
    localparam int TD  = 4;
    localparam int GAP = 1;
    localparam int NE  = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data = '0;
    logic          busy, done, buzzer;

    logic [31:0] rom_mem [NE];

    buzzer_melody_player #(.ADDR_W(AW), .TICK_DIV(TD), .GAP_TICKS(GAP)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .stop     (stop),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .done     (done),
        .buzzer   (buzzer)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after address.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          buz;
        logic [AW-1:0] addr;
    } obs_t;

    typedef struct packed {
        logic [NE-1:0][31:0] rom;
        int busy_cyc;
        int high_cyc;
        int rises;
    } vec_t;

    obs_t exp_q [$];
    vec_t vecs [4];
    int   n_pass = 0;
    int   n_total = 0;
    int   m_busy, m_high, m_rises, m_done;
    logic m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic obs_t cur_obs();
        obs_t o;
        o.busy = busy; o.done = done; o.buz = buzzer; o.addr = rom_addr;
        return o;
    endfunction

    function automatic obs_t mk(input logic b, input logic d, input logic z, input int a);
        obs_t o;
        o.busy = b; o.done = d; o.buz = z; o.addr = AW'(a);
        return o;
    endfunction

    // Expected per-cycle timeline, starting with the cycle after start is taken.
    task automatic build_model();
        bit ended = 0;
        exp_q.delete();
        for (int a = 0; a < NE && !ended; a++) begin
            int hp  = int'(rom_mem[a][31:16]);
            int dur = int'(rom_mem[a][15:0]);
            exp_q.push_back(mk(1, 0, 0, a));
            exp_q.push_back(mk(1, 0, 0, a));
            if (dur == 0) begin
                exp_q.push_back(mk(1, 1, 0, a));
                ended = 1;
            end else begin
                for (int k = 0; k < dur * TD; k++)
                    exp_q.push_back(mk(1, 0, (hp == 0) ? 1'b0 : 1'((k / (hp + 1)) % 2), a));
                for (int k = 0; k < GAP * TD; k++)
                    exp_q.push_back(mk(1, 0, 0, a));
                exp_q.push_back(mk(1, 0, 0, a));
            end
        end
        if (!ended) exp_q.push_back(mk(1, 1, 0, NE - 1));
        exp_q.push_back(mk(0, 0, 0, 0));
    endtask

    // Called at posedge+1 with the DUT idle: take one start, step through the model.
    task automatic run_trace(input bit junk, input string tag);
        build_model();
        m_busy = 0; m_high = 0; m_rises = 0; m_done = 0; m_prev = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        foreach (exp_q[i]) begin
            check($sformatf("%s trace[%0d]", tag, i), 32'(cur_obs()), 32'(exp_q[i]));
            if (busy) m_busy++;
            if (buzzer) m_high++;
            if (buzzer && !m_prev) m_rises++;
            if (done) m_done++;
            m_prev = buzzer;
            start = (junk && exp_q[i].busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic load_vec(input int v);
        for (int a = 0; a < NE; a++) rom_mem[a] = vecs[v].rom[a];
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < NE; a++) rom_mem[a] = '0;
        for (int v = 0; v < 4; v++) vecs[v] = '0;
        // single note hp=2 dur=3 then end
        vecs[0].rom[0] = {16'd2, 16'd3};
        vecs[0].busy_cyc = 22; vecs[0].high_cyc = 6; vecs[0].rises = 2;
        // rest of 2 ticks, then hp=1 for 1 tick, then end
        vecs[1].rom[0] = {16'd0, 16'd2};
        vecs[1].rom[1] = {16'd1, 16'd1};
        vecs[1].busy_cyc = 29; vecs[1].high_cyc = 2; vecs[1].rises = 1;
        // all eight entries, no end marker
        for (int a = 0; a < NE; a++) vecs[2].rom[a] = {16'd1, 16'd1};
        vecs[2].busy_cyc = 89; vecs[2].high_cyc = 16; vecs[2].rises = 8;
        // end marker at address 0
        vecs[3].rom[0] = {16'd5, 16'd0};
        vecs[3].busy_cyc = 3; vecs[3].high_cyc = 0; vecs[3].rises = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 32'(cur_obs()), 32'(mk(0, 0, 0, 0)));
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            run_trace(1'b0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d busy cycles", v), 32'(m_busy), 32'(vecs[v].busy_cyc));
            check($sformatf("vec%0d high cycles", v), 32'(m_high), 32'(vecs[v].high_cyc));
            check($sformatf("vec%0d rises", v), 32'(m_rises), 32'(vecs[v].rises));
            check($sformatf("vec%0d done pulses", v), 32'(m_done), 32'd1);
        end

        // start pulses while busy must not disturb the timeline
        load_vec(1);
        run_trace(1'b1, "busy_start");

        // stop in the middle of the second note while the tone is high
        load_vec(2);
        kick();
        repeat (15) @(posedge clk);
        #1;
        check("pre-stop buzzer", 32'(buzzer), 32'd1);
        check("pre-stop addr", 32'(rom_addr), 32'd1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("after stop", 32'(cur_obs()), 32'(mk(0, 0, 0, 0)));
        m_busy = 0; m_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy) m_busy++;
            if (done) m_done++;
            @(posedge clk); #1;
        end
        check("after stop busy", 32'(m_busy), 32'd0);
        check("after stop done", 32'(m_done), 32'd0);

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        check("start+stop", 32'(cur_obs()), 32'(mk(0, 0, 0, 0)));
        @(posedge clk); #1;
        check("start+stop later", 32'(busy), 32'd0);

        // reset during the gap
        load_vec(0);
        kick();
        repeat (15) @(posedge clk);
        #1;
        check("in gap busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("reset mid-gap", 32'(cur_obs()), 32'(mk(0, 0, 0, 0)));
        resetn = 1'b1;
        @(posedge clk); #1;
        run_trace(1'b0, "post_reset");

        // random melodies
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < NE; a++) begin
                logic [15:0] hp, dur;
                hp  = 16'($urandom_range(0, 3));
                dur = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 3));
                rom_mem[a] = {hp, dur};
            end
            run_trace(r[0], $sformatf("rand%0d", r));
            check($sformatf("rand%0d done pulses", r), 32'(m_done), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
